// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC constants, TX state type and CRC-32 byte step
package mac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PTR_WAIT,
    S_PTR_LATCH,
    S_PREAMBLE,
    S_DATA,
    S_PAD,
    S_FCS,
    S_DRAIN,
    S_IFG
  } tx_state_e;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Ethernet bit order is LSB first, so the register shifts right with the reflected polynomial.
  function automatic logic [31:0] crc32_next8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic [31:0] poly_r;
    poly_r = reflect32(CRC_POLY);
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - byte-wide CRC-32 accumulator with init and enable
module crc32_d8
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = CRC_INIT;
    else if (en_i) crc_d = crc32_next8(crc_q, data_i);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/mac_tx_gmii.sv
// rtl/mac_tx_gmii.sv - GMII transmit framer: preamble/SFD, pad, FCS, inter-frame gap
// Build option: define MAC_TX_PAD_EN to pad short frames up to MIN_LEN.
module mac_tx_gmii
  import mac_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514
) (
  input  logic        clk,
  input  logic        rst,
  output logic        tx_ptr_fifo_rd,
  input  logic [15:0] tx_ptr_fifo_din,
  input  logic        tx_ptr_fifo_empty,
  output logic        tx_data_fifo_rd,
  input  logic [7:0]  tx_data_fifo_din,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        frame_done,
  output logic        frame_drop
);

  localparam int IFGW = $clog2(IFG_CYCLES + 1);
  // The pop/wait/latch pipeline supplies the last three idle cycles of the gap.
  localparam logic [IFGW-1:0] IFG_WAIT = IFGW'(IFG_CYCLES - 3);

  tx_state_e        state_q, state_d;
  logic             ptr_rd_q, ptr_rd_d, data_rd_q, data_rd_d;
  logic [7:0]       txd_q, txd_d;
  logic             tx_en_q, tx_en_d, tx_er_q, done_q, done_d, drop_q, drop_d;
  logic [10:0]      rd_left_q, rd_left_d, data_left_q, data_left_d;
  logic [2:0]       pre_q, pre_d;
  logic [1:0]       fcs_q, fcs_d;
  logic [IFGW-1:0]  ifg_q, ifg_d;
  logic             crc_init, crc_en;
  logic [7:0]       crc_data;
  logic [31:0]      crc_q, fcs_word;
  logic [10:0]      len;
  logic [4:0]       unused_din;
`ifdef MAC_TX_PAD_EN
  logic [5:0]       pad_q, pad_d;
`else
  logic [10:0]      unused_min;
  assign unused_min = 11'(MIN_LEN);
`endif

  assign len        = tx_ptr_fifo_din[10:0];
  assign unused_din = tx_ptr_fifo_din[15:11];
  assign fcs_word   = ~crc_q;

  crc32_d8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (crc_data),
    .crc_o  (crc_q)
  );

  always_comb begin
    state_d     = state_q;
    ptr_rd_d    = 1'b0;
    data_rd_d   = 1'b0;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    done_d      = 1'b0;
    drop_d      = 1'b0;
    rd_left_d   = rd_left_q;
    data_left_d = data_left_q;
    pre_d       = pre_q;
    fcs_d       = fcs_q;
    ifg_d       = ifg_q;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    crc_data    = tx_data_fifo_din;
`ifdef MAC_TX_PAD_EN
    pad_d       = pad_q;
`endif
    case (state_q)
      S_IDLE: if (!tx_ptr_fifo_empty) begin
        ptr_rd_d = 1'b1;
        state_d  = S_PTR_WAIT;
      end
      S_PTR_WAIT: state_d = S_PTR_LATCH;
      S_PTR_LATCH: begin
        rd_left_d   = len;
        data_left_d = len;
        pre_d       = 3'd0;
        fcs_d       = 2'd0;
        crc_init    = 1'b1;
`ifdef MAC_TX_PAD_EN
        pad_d = (len < 11'(MIN_LEN)) ? 6'(MIN_LEN - int'(len)) : 6'd0;
`endif
        if (len == 11'd0)                state_d = S_IDLE;
        else if (len > 11'(MAX_LEN))     state_d = S_DRAIN;
        else                             state_d = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = (pre_q == 3'd7) ? SFD_BYTE : PREAMBLE_BYTE;
        pre_d   = pre_q + 3'd1;
        if (pre_q == 3'd7) state_d = S_DATA;
      end
      S_DATA: begin
        tx_en_d     = 1'b1;
        txd_d       = tx_data_fifo_din;
        crc_en      = 1'b1;
        data_left_d = data_left_q - 11'd1;
        if (data_left_q == 11'd1) begin
`ifdef MAC_TX_PAD_EN
          state_d = (pad_q != 6'd0) ? S_PAD : S_FCS;
`else
          state_d = S_FCS;
`endif
        end
      end
`ifdef MAC_TX_PAD_EN
      S_PAD: begin
        tx_en_d  = 1'b1;
        crc_en   = 1'b1;
        crc_data = 8'h00;
        pad_d    = pad_q - 6'd1;
        if (pad_q == 6'd1) state_d = S_FCS;
      end
`endif
      S_FCS: begin
        tx_en_d = 1'b1;
        txd_d   = fcs_word[{fcs_q, 3'b000} +: 8];
        fcs_d   = fcs_q + 2'd1;
        if (fcs_q == 2'd3) begin
          done_d  = 1'b1;
          ifg_d   = IFG_WAIT;
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        ifg_d = ifg_q - IFGW'(1);
        if (ifg_q == IFGW'(1)) state_d = S_IDLE;
      end
      S_DRAIN: begin
        data_rd_d = 1'b1;
        rd_left_d = rd_left_q - 11'd1;
        if (rd_left_q == 11'd1) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Reads lead the wire by two cycles: one for FIFO latency, one for the output register.
    if (((state_q == S_PREAMBLE) && (pre_q >= 3'd6)) || (state_q == S_DATA)) begin
      if (rd_left_q != 11'd0) begin
        data_rd_d = 1'b1;
        rd_left_d = rd_left_q - 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_rd_q    <= 1'b0;
      data_rd_q   <= 1'b0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      rd_left_q   <= 11'd0;
      data_left_q <= 11'd0;
      pre_q       <= 3'd0;
      fcs_q       <= 2'd0;
      ifg_q       <= '0;
`ifdef MAC_TX_PAD_EN
      pad_q       <= 6'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_rd_q    <= ptr_rd_d;
      data_rd_q   <= data_rd_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= 1'b0;
      done_q      <= done_d;
      drop_q      <= drop_d;
      rd_left_q   <= rd_left_d;
      data_left_q <= data_left_d;
      pre_q       <= pre_d;
      fcs_q       <= fcs_d;
      ifg_q       <= ifg_d;
`ifdef MAC_TX_PAD_EN
      pad_q       <= pad_d;
`endif
    end
  end

  assign tx_ptr_fifo_rd  = ptr_rd_q;
  assign tx_data_fifo_rd = data_rd_q;
  assign gmii_txd        = txd_q;
  assign gmii_tx_en      = tx_en_q;
  assign gmii_tx_er      = tx_er_q;
  assign frame_done      = done_q;
  assign frame_drop      = drop_q;

endmodule

// File: tb/tb_mac_tx_gmii.sv
// tb/tb_mac_tx_gmii.sv - randomized self-checking bench for mac_tx_gmii
module tb_mac_tx_gmii;

  localparam int IFG  = 12;
  localparam int MINL = 60;
  localparam int MAXL = 1514;
`ifdef MAC_TX_PAD_EN
  localparam int PADMIN = MINL;
`else
  localparam int PADMIN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_ptr_fifo_rd, tx_data_fifo_rd;
  logic [15:0] tx_ptr_fifo_din = 16'h0;
  logic        tx_ptr_fifo_empty = 1'b1;
  logic [7:0]  tx_data_fifo_din = 8'h0;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en, gmii_tx_er, frame_done, frame_drop;

  mac_tx_gmii #(.IFG_CYCLES(IFG), .MIN_LEN(MINL), .MAX_LEN(MAXL)) dut (
    .clk               (clk),
    .rst               (rst),
    .tx_ptr_fifo_rd    (tx_ptr_fifo_rd),
    .tx_ptr_fifo_din   (tx_ptr_fifo_din),
    .tx_ptr_fifo_empty (tx_ptr_fifo_empty),
    .tx_data_fifo_rd   (tx_data_fifo_rd),
    .tx_data_fifo_din  (tx_data_fifo_din),
    .gmii_txd          (gmii_txd),
    .gmii_tx_en        (gmii_tx_en),
    .gmii_tx_er        (gmii_tx_er),
    .frame_done        (frame_done),
    .frame_drop        (frame_drop)
  );

  always #5 clk = ~clk;

  // Standard (non-FWFT) FIFOs, cleared by the shared reset
  logic [15:0] ptr_q[$];
  logic [7:0]  data_q[$];
  always @(posedge clk) begin
    if (rst) begin
      ptr_q.delete();
      data_q.delete();
      tx_ptr_fifo_din  <= 16'h0;
      tx_data_fifo_din <= 8'h0;
    end else begin
      if (tx_ptr_fifo_rd && ptr_q.size() > 0) tx_ptr_fifo_din <= ptr_q.pop_front();
      if (tx_data_fifo_rd && data_q.size() > 0) tx_data_fifo_din <= data_q.pop_front();
    end
  end
  always @(negedge clk) tx_ptr_fifo_empty <= (ptr_q.size() == 0);

  // Wire monitor
  int          cyc = 0, cur_len = 0, n_data_rd = 0, n_done = 0, n_drop = 0, n_er = 0, n_idle_bad = 0;
  logic        prev_en = 1'b0, last_done = 1'b0;
  logic [7:0]  wire_bytes[$];
  int          frame_lens[$], rise_cyc[$], fall_cyc[$], ptr_rd_cyc[$];
  bit          done_last[$];
  always @(negedge clk) begin
    cyc++;
    if (tx_ptr_fifo_rd) ptr_rd_cyc.push_back(cyc);
    if (tx_data_fifo_rd) n_data_rd++;
    if (frame_done) n_done++;
    if (frame_drop) n_drop++;
    if (gmii_tx_er) n_er++;
    if (gmii_tx_en) begin
      if (!prev_en) begin
        rise_cyc.push_back(cyc);
        cur_len = 0;
      end
      wire_bytes.push_back(gmii_txd);
      cur_len++;
      last_done = frame_done;
    end else begin
      if (prev_en) begin
        fall_cyc.push_back(cyc);
        frame_lens.push_back(cur_len);
        done_last.push_back(last_done);
      end
      if (gmii_txd != 8'h00) n_idle_bad++;
    end
    prev_en = gmii_tx_en;
  end

  // Reference model state
  int          n_tests = 0, n_fail = 0;
  logic [7:0]  exp_bytes[$];
  int          exp_lens[$];
  bit          exp_full[$];
  int          exp_done = 0, exp_drops = 0;
  int          vi = 0, w_off = 0, e_off = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) c = ((c[0] ^ b[i]) == 1'b1) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Queue a frame in both FIFOs and build the expected wire image; cut>=0 models a reset abort
  task automatic send_frame(input int len, input bit incr, input int cut);
    logic [7:0]  pl[$];
    logic [7:0]  b;
    logic [31:0] crc;
    int          body;
    for (int i = 0; i < len; i++) begin
      b = incr ? 8'(i) : 8'($urandom);
      pl.push_back(b);
      data_q.push_back(b);
    end
    ptr_q.push_back({5'($urandom), 11'(len)});
    if (len == 0) return;
    if (len > MAXL) begin
      exp_drops++;
      return;
    end
    for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    if (cut >= 0) begin
      for (int i = 0; i < cut; i++) exp_bytes.push_back(pl[i]);
      exp_lens.push_back(8 + cut);
      exp_full.push_back(1'b0);
      return;
    end
    body = (len < PADMIN) ? PADMIN : len;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < body; i++) begin
      b = (i < len) ? pl[i] : 8'h00;
      exp_bytes.push_back(b);
      crc = crc_byte(crc, b);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) exp_bytes.push_back(crc[8*i +: 8]);
    exp_lens.push_back(8 + body + 4);
    exp_full.push_back(1'b1);
    exp_done++;
  endtask

  task automatic wait_quiet();
    int t;
    t = 0;
    while ((frame_lens.size() < exp_lens.size() || n_drop < exp_drops) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk("timeout", 32'(t), 32'd0);
    repeat (IFG + 8) @(negedge clk);
  endtask

  task automatic verify_frames();
    int          el, wl, bad;
    logic [31:0] c;
    while (vi < exp_lens.size()) begin
      if (vi >= frame_lens.size()) begin
        chk("frame_count", 32'(frame_lens.size()), 32'(exp_lens.size()));
        return;
      end
      el = exp_lens[vi];
      wl = frame_lens[vi];
      bad = 0;
      chk($sformatf("wire_len[%0d]", vi), 32'(wl), 32'(el));
      for (int i = 0; i < el && i < wl; i++)
        if (wire_bytes[w_off+i] !== exp_bytes[e_off+i]) bad++;
      chk($sformatf("bytes[%0d]", vi), 32'(bad), 32'd0);
      if (exp_full[vi]) begin
        c = 32'hFFFFFFFF;
        for (int i = 8; i < wl; i++) c = crc_byte(c, wire_bytes[w_off+i]);
        chk($sformatf("residue[%0d]", vi), c, 32'hDEBB20E3);
      end
      chk($sformatf("done_on_last[%0d]", vi), 32'(done_last[vi]), 32'(exp_full[vi]));
      w_off += wl;
      e_off += el;
      vi++;
    end
  endtask

  initial begin
    int p0, r0, f0, d0, len, t;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {tx_ptr_fifo_rd, tx_data_fifo_rd, gmii_txd, gmii_tx_en, gmii_tx_er, frame_done, frame_drop}, 32'd0);
    rst = 1'b0;

    // Single len=64 frame, incrementing payload
    p0 = ptr_rd_cyc.size(); r0 = n_data_rd; f0 = frame_lens.size();
    @(posedge clk); #1;
    send_frame(64, 1'b1, -1);
    wait_quiet();
    verify_frames();
    chk("ptr_pops_64", 32'(ptr_rd_cyc.size() - p0), 32'd1);
    chk("reads_64", 32'(n_data_rd - r0), 32'd64);
    if (rise_cyc.size() > f0 && ptr_rd_cyc.size() > p0)
      chk("pop_to_tx_en", 32'(rise_cyc[f0] - ptr_rd_cyc[p0]), 32'd3);
    else
      chk("pop_to_tx_en_seen", 32'd0, 32'd1);

    // Short frame: padded or native depending on build
    @(posedge clk); #1;
    send_frame(20, 1'b0, -1);
    wait_quiet();
    verify_frames();

    // Three back-to-back len=60 frames at line rate
    r0 = n_data_rd; f0 = frame_lens.size();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_frame(60, 1'b0, -1);
    wait_quiet();
    verify_frames();
    chk("reads_b2b", 32'(n_data_rd - r0), 32'd180);
    if (rise_cyc.size() >= f0 + 3) begin
      chk("ifg_gap0", 32'(rise_cyc[f0+1] - fall_cyc[f0]), 32'(IFG));
      chk("ifg_gap1", 32'(rise_cyc[f0+2] - fall_cyc[f0+1]), 32'(IFG));
    end else chk("b2b_frames_seen", 32'(rise_cyc.size() - f0), 32'd3);

    // Oversize drop followed by a normal frame
    r0 = n_data_rd; f0 = frame_lens.size(); d0 = n_drop;
    @(posedge clk); #1;
    send_frame(MAXL + 1, 1'b0, -1);
    send_frame(64, 1'b0, -1);
    wait_quiet();
    verify_frames();
    chk("reads_drop", 32'(n_data_rd - r0), 32'(MAXL + 1 + 64));
    chk("drop_pulses", 32'(n_drop - d0), 32'd1);
    chk("frames_after_drop", 32'(frame_lens.size() - f0), 32'd1);

    // Zero-length descriptor, then a random frame
    p0 = ptr_rd_cyc.size(); r0 = n_data_rd; f0 = frame_lens.size();
    len = $urandom_range(1, 100);
    @(posedge clk); #1;
    send_frame(0, 1'b0, -1);
    send_frame(len, 1'b0, -1);
    wait_quiet();
    verify_frames();
    chk("ptr_pops_zero", 32'(ptr_rd_cyc.size() - p0), 32'd2);
    chk("reads_zero", 32'(n_data_rd - r0), 32'(len));
    chk("frames_zero", 32'(frame_lens.size() - f0), 32'd1);

    // Length boundaries, back-to-back
    @(posedge clk); #1;
    send_frame(MINL, 1'b0, -1);
    send_frame(MAXL, 1'b0, -1);
    send_frame(MINL - 1, 1'b0, -1);
    send_frame(1, 1'b0, -1);
    wait_quiet();
    verify_frames();

    // Random lengths, preloaded
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send_frame($urandom_range(1, 150), 1'b0, -1);
    wait_quiet();
    verify_frames();

    // Reset while payload byte 30 of a len=100 frame is on the wire
    @(posedge clk); #1;
    send_frame(100, 1'b0, 31);
    t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (!(gmii_tx_en && cur_len == 39) && t < 2000);
    if (t >= 2000) chk("abort_point_reached", 32'd0, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx_en", 32'(gmii_tx_en), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame($urandom_range(1, 120), 1'b0, -1);
    wait_quiet();
    verify_frames();

    chk("done_total", 32'(n_done), 32'(exp_done));
    chk("drop_total", 32'(n_drop), 32'(exp_drops));
    chk("tx_er_never", 32'(n_er), 32'd0);
    chk("idle_txd_zero", 32'(n_idle_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
